nx_node_data_arbiter: RTL
=========================

Name: nx_node_data_arbiter

Overview:
- Shares the node's single-port 1024x32 data RAM between two requesters: the node execution core and the inbound message path (external load/store and readback).
- Core has absolute priority, because it has no stall input on its data port.
- External requests use a valid/ready handshake and are served in idle core cycles.
- External read data returns through a small response FIFO with its own valid/ready handshake.
- Sits between nx_node_core, the inbound decoder and the data RAM inside the node.

Parameters:
- RSP_DEPTH, 2, external read-response FIFO entries (>=1).
- STARVE_LIMIT, 64, consecutive blocked cycles before o_starved asserts (>=1).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_core_addr  input  10  core RAM address
- i_core_wr_data  input  32  core write data
- i_core_wr_strb  input  32  core per-bit write mask
- i_core_rd_en  input  1  core read request
- o_core_rd_data  output  32  core read data (RAM data passthrough)
- i_ext_addr  input  10  external address
- i_ext_wr_data  input  32  external write data
- i_ext_wr_strb  input  32  external per-bit write mask
- i_ext_rd_en  input  1  1=read, 0=write
- i_ext_valid  input  1  external request valid
- o_ext_ready  output  1  external request accepted
- o_ext_rsp_data  output  32  external read response data
- o_ext_rsp_valid  output  1  response valid
- i_ext_rsp_ready  input  1  response consumed
- o_ram_addr  output  10  RAM address
- o_ram_wr_data  output  32  RAM write data
- o_ram_wr_strb  output  32  RAM per-bit write mask
- o_ram_rd_en  output  1  RAM read enable
- i_ram_rd_data  input  32  RAM read data, 1-cycle latency
- o_starved  output  1  external requester blocked for STARVE_LIMIT cycles

Behaviour:
- Request and grant:
  - core_act = i_core_rd_en || |i_core_wr_strb.
  - When core_act is high, the RAM is driven combinationally from the core inputs in the same cycle, with zero added latency.
  - credit_ok = (rsp_inflight + fifo_count) < RSP_DEPTH; rsp_inflight is 1 if an external read was issued last cycle.
  - o_ext_ready = !core_act && credit_ok. It does not depend on i_ext_valid.
  - External handshake (valid && ready): the RAM is driven from the ext inputs. For writes, rd_en=0 and strb=i_ext_wr_strb. For reads, strb=0 and rd_en=1.
  - No grant: o_ram_rd_en=0, o_ram_wr_strb=0, and addr/data hold 0.
- Read responses:
  - A registered flag rsp_inflight is set by an external read handshake.
  - In the following cycle i_ram_rd_data is pushed into the FIFO (tail).
  - o_ext_rsp_valid = fifo non-empty; o_ext_rsp_data = FIFO head; pop when valid && i_ext_rsp_ready.
  - Push and pop in the same cycle are both allowed, including at full (pop frees the slot) and at empty (push-through is not required: the data appears at the head one cycle after the push).
  - Minimum request-to-response latency is 2 cycles.
  - The credit rule guarantees a push never overflows.
  - Read pointers wrap modulo RSP_DEPTH. Count width is $clog2(RSP_DEPTH+1).
- Core read data:
  - o_core_rd_data = i_ram_rd_data, unconditional. The core tracks its own pending reads.
- Starvation:
  - starve_cnt increments when i_ext_valid && !o_ext_ready, saturating at STARVE_LIMIT.
  - starve_cnt clears on any handshake or when i_ext_valid is low.
  - o_starved = (starve_cnt == STARVE_LIMIT). It is registered, so it rises on the clock edge where the count reaches the limit.
  - o_starved is informational only; grant priority is unchanged.
- Reset values:
  - rsp_inflight=0, FIFO empty, o_ext_rsp_valid=0, o_ext_rsp_data=0, starve_cnt=0, o_starved=0.
  - Combinational outputs follow their inputs.
  - A reset mid-operation discards the in-flight read and all queued responses.

Optional Feature:
- Macro: NX_DATA_ARB_STATS_EN.
- When defined, adds ports o_core_grants (output, 16) and o_ext_grants (output, 16): saturating counts of core_act cycles and external handshakes, reset to 0, plus input i_stats_clear (1), which zeroes both counters on the next edge and takes priority over increment.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Core write addr 0x005, strb 0x000000FF, data 0xA5A5A5A5 while ext valid -> RAM sees the core write the same cycle; o_ext_ready=0; ext granted the next idle cycle.
- Ext write 0x3FF, strb all ones, data 0xDEADBEEF, then ext read 0x3FF in idle cycles -> o_ext_rsp_valid rises 2 cycles after the read handshake with data 0xDEADBEEF.
- Hold i_ext_rsp_ready=0 and issue 3 ext reads (RSP_DEPTH=2) -> only 2 accepted, o_ext_ready=0 after the second; one pop reopens ready; responses come out in order.
- core_act held high for 70 cycles with ext valid (STARVE_LIMIT=64) -> o_starved=1 from cycle 64 onward; drops one cycle after the ext handshake.
- Assert i_rst with an in-flight read and 1 queued response -> o_ext_rsp_valid=0 immediately (async reset); no response appears after reset releases.
- NX_DATA_ARB_STATS_EN: 5 core cycles and 3 ext handshakes -> o_core_grants=5, o_ext_grants=3; after i_stats_clear both read 0.

Source files
------------

// File: rtl/nx_node_data_arbiter_if.sv
// External request/response bundle for the node data arbiter.
// master = inbound message path, slave = arbiter.
//
// Handshake rules, for both channels:
//   A transfer happens on a rising clk edge where valid and ready are both high.
//   Request channel: the requester holds i_ext_* stable while i_ext_valid is high
//   until that edge. o_ext_ready never depends on i_ext_valid.
//   Response channel: o_ext_rsp_data is stable while o_ext_rsp_valid is high,
//   and the entry is popped on the edge where i_ext_rsp_ready is also high.
interface nx_node_data_arbiter_if;
  logic [9:0]  i_ext_addr;
  logic [31:0] i_ext_wr_data;
  logic [31:0] i_ext_wr_strb;
  logic        i_ext_rd_en;
  logic        i_ext_valid;
  logic        o_ext_ready;
  logic [31:0] o_ext_rsp_data;
  logic        o_ext_rsp_valid;
  logic        i_ext_rsp_ready;

  modport master (
    output i_ext_addr, i_ext_wr_data, i_ext_wr_strb, i_ext_rd_en, i_ext_valid,
    input  o_ext_ready, o_ext_rsp_data, o_ext_rsp_valid,
    output i_ext_rsp_ready
  );

  modport slave (
    input  i_ext_addr, i_ext_wr_data, i_ext_wr_strb, i_ext_rd_en, i_ext_valid,
    output o_ext_ready, o_ext_rsp_data, o_ext_rsp_valid,
    input  i_ext_rsp_ready
  );
endinterface

// File: rtl/nx_node_data_arbiter.sv
// Node data RAM arbiter: the execution core owns the RAM whenever it is active
// (it cannot stall), external requests fill idle cycles, and external read data
// comes back through a small response FIFO.
// Optional grant statistics are enabled with the macro NX_DATA_ARB_STATS_EN.
module nx_node_data_arbiter #(
  parameter int RSP_DEPTH    = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_core_addr,
  input  logic [31:0] i_core_wr_data,
  input  logic [31:0] i_core_wr_strb,
  input  logic        i_core_rd_en,
  output logic [31:0] o_core_rd_data,
  nx_node_data_arbiter_if.slave ext,
  output logic [9:0]  o_ram_addr,
  output logic [31:0] o_ram_wr_data,
  output logic [31:0] o_ram_wr_strb,
  output logic        o_ram_rd_en,
  input  logic [31:0] i_ram_rd_data,
  output logic        o_starved
`ifdef NX_DATA_ARB_STATS_EN
  ,
  input  logic        i_stats_clear,
  output logic [15:0] o_core_grants,
  output logic [15:0] o_ext_grants
`endif
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic          core_act;
  logic          credit_ok;
  logic          ext_fire;
  logic          rsp_inflight;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [31:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] starve_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Grant decision: core wins outright; ext only gets a slot when the core is
  // idle and a response slot is reserved for a possible read.
  always_comb begin
    core_act        = i_core_rd_en || (|i_core_wr_strb);
    occupancy       = {{CW{1'b0}}, rsp_inflight} + {1'b0, fifo_count};
    credit_ok       = occupancy < DEPTH_C;
    ext.o_ext_ready = !core_act && credit_ok;
    ext_fire        = ext.i_ext_valid && ext.o_ext_ready;
    push            = rsp_inflight;
    pop             = (fifo_count != '0) && ext.i_ext_rsp_ready;
  end

  // RAM port mux: core inputs pass straight through, ext drives only on a handshake.
  always_comb begin
    o_ram_addr    = '0;
    o_ram_wr_data = '0;
    o_ram_wr_strb = '0;
    o_ram_rd_en   = 1'b0;
    if (core_act) begin
      o_ram_addr    = i_core_addr;
      o_ram_wr_data = i_core_wr_data;
      o_ram_wr_strb = i_core_wr_strb;
      o_ram_rd_en   = i_core_rd_en;
    end else if (ext_fire) begin
      o_ram_addr    = ext.i_ext_addr;
      o_ram_wr_data = ext.i_ext_wr_data;
      o_ram_wr_strb = ext.i_ext_rd_en ? 32'h0 : ext.i_ext_wr_strb;
      o_ram_rd_en   = ext.i_ext_rd_en;
    end
  end

  // The core keeps its own record of pending reads, so its data is a plain passthrough.
  assign o_core_rd_data = i_ram_rd_data;

  // Marks that the RAM returns an external read result on the next cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rsp_inflight <= 1'b0;
    else       rsp_inflight <= ext_fire && ext.i_ext_rd_en;
  end

  // Response FIFO storage and pointers; the credit check keeps pushes from overflowing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= i_ram_rd_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign ext.o_ext_rsp_valid = (fifo_count != '0);
  assign ext.o_ext_rsp_data  = fifo_mem[rd_ptr];

  // Count consecutive blocked cycles of a waiting external request, saturating.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            starve_cnt <= '0;
    else if (!ext.i_ext_valid || ext_fire) starve_cnt <= '0;
    else if (starve_cnt != LIMIT_C)       starve_cnt <= starve_cnt + 1'b1;
  end

  // Flag is decoded from the registered count, so it changes only on clock edges.
  assign o_starved = (starve_cnt == LIMIT_C);

`ifdef NX_DATA_ARB_STATS_EN
  // Saturating grant counters; clear overrides counting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_core_grants <= '0;
      o_ext_grants  <= '0;
    end else if (i_stats_clear) begin
      o_core_grants <= '0;
      o_ext_grants  <= '0;
    end else begin
      if (core_act && o_core_grants != 16'hFFFF) o_core_grants <= o_core_grants + 1'b1;
      if (ext_fire && o_ext_grants != 16'hFFFF)  o_ext_grants  <= o_ext_grants + 1'b1;
    end
  end
`endif

endmodule
